// File: rtl/lock_scheduler.sv
// Canal lock sequencer: arbitrates arrival/departure passages and sequences the gates and water level.
// Optional feature macro LOCK_HOLD_EN adds a hold input that freezes the open-gate timer.
module lock_scheduler #(
    parameter int unsigned LEVEL_MAX   = 7,
    parameter int unsigned GATE_CYCLES = 4
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           arr_req,
    input  logic                           dept_req,
`ifdef LOCK_HOLD_EN
    input  logic                           hold,
`endif
    output logic                           arr_grant,
    output logic                           dept_grant,
    output logic                           outer_open,
    output logic                           inner_open,
    output logic                           fill,
    output logic                           drain,
    output logic [$clog2(LEVEL_MAX+1)-1:0] water_level,
    output logic                           busy
);

    localparam int unsigned LW = $clog2(LEVEL_MAX + 1);
    localparam int unsigned TW = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
    localparam logic [LW-1:0] LVL_TOP  = LW'(LEVEL_MAX);
    localparam logic [TW-1:0] TMR_LAST = TW'(GATE_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREP,
        S_ENTRY_OPEN,
        S_LEVEL,
        S_EXIT_OPEN
    } state_t;

    state_t        state_q, state_n;
    logic          dir_q, dir_n;          // 0 = arrival, 1 = departure
    logic [TW-1:0] timer_q, timer_n;
    logic [LW-1:0] level_n;
    logic          arr_pend_q, arr_pend_n;
    logic          dept_pend_q, dept_pend_n;
    logic          eff_arr, eff_dept, take_dept;
    logic          hold_w;
    logic          arr_grant_n, dept_grant_n;
    logic          outer_open_n, inner_open_n, fill_n, drain_n, busy_n;

`ifdef LOCK_HOLD_EN
    assign hold_w = hold;
`else
    assign hold_w = 1'b0;
`endif

    // Next-state, water level, pending flags and registered-output decode
    always_comb begin
        state_n      = state_q;
        dir_n        = dir_q;
        timer_n      = timer_q;
        arr_pend_n   = arr_pend_q  | (arr_req  & (state_q != S_IDLE));
        dept_pend_n  = dept_pend_q | (dept_req & (state_q != S_IDLE));
        arr_grant_n  = 1'b0;
        dept_grant_n = 1'b0;
        eff_arr      = arr_req  | arr_pend_q;
        eff_dept     = dept_req | dept_pend_q;
        // Prefer the passage whose entry side already matches the water
        take_dept    = eff_dept & (~eff_arr | (water_level == LVL_TOP));

        level_n = water_level;
        if (fill && (water_level != LVL_TOP)) begin
            level_n = water_level + LW'(1);
        end else if (drain && (water_level != '0)) begin
            level_n = water_level - LW'(1);
        end

        case (state_q)
            S_IDLE: begin
                if (eff_arr | eff_dept) begin
                    dir_n   = take_dept;
                    timer_n = '0;
                    if (take_dept) begin
                        dept_grant_n = 1'b1;
                        dept_pend_n  = 1'b0;
                        state_n      = (water_level == LVL_TOP) ? S_ENTRY_OPEN : S_PREP;
                    end else begin
                        arr_grant_n = 1'b1;
                        arr_pend_n  = 1'b0;
                        state_n     = (water_level == '0) ? S_ENTRY_OPEN : S_PREP;
                    end
                end
            end
            S_PREP: begin
                if (level_n == (dir_q ? LVL_TOP : '0)) begin
                    state_n = S_ENTRY_OPEN;
                    timer_n = '0;
                end
            end
            S_ENTRY_OPEN: begin
                if (!hold_w) begin
                    if (timer_q == TMR_LAST) begin
                        state_n = S_LEVEL;
                    end else begin
                        timer_n = timer_q + TW'(1);
                    end
                end
            end
            S_LEVEL: begin
                if (level_n == (dir_q ? '0 : LVL_TOP)) begin
                    state_n = S_EXIT_OPEN;
                    timer_n = '0;
                end
            end
            S_EXIT_OPEN: begin
                if (!hold_w) begin
                    if (timer_q == TMR_LAST) begin
                        state_n = S_IDLE;
                    end else begin
                        timer_n = timer_q + TW'(1);
                    end
                end
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase

        // Outer gate faces low water, inner gate faces high water
        busy_n       = (state_n != S_IDLE);
        outer_open_n = ((state_n == S_ENTRY_OPEN) & ~dir_n) | ((state_n == S_EXIT_OPEN) &  dir_n);
        inner_open_n = ((state_n == S_ENTRY_OPEN) &  dir_n) | ((state_n == S_EXIT_OPEN) & ~dir_n);
        fill_n       = ((state_n == S_PREP) &  dir_n) | ((state_n == S_LEVEL) & ~dir_n);
        drain_n      = ((state_n == S_PREP) & ~dir_n) | ((state_n == S_LEVEL) &  dir_n);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            dir_q       <= 1'b0;
            timer_q     <= '0;
            arr_pend_q  <= 1'b0;
            dept_pend_q <= 1'b0;
            water_level <= '0;
            arr_grant   <= 1'b0;
            dept_grant  <= 1'b0;
            outer_open  <= 1'b0;
            inner_open  <= 1'b0;
            fill        <= 1'b0;
            drain       <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state_q     <= state_n;
            dir_q       <= dir_n;
            timer_q     <= timer_n;
            arr_pend_q  <= arr_pend_n;
            dept_pend_q <= dept_pend_n;
            water_level <= level_n;
            arr_grant   <= arr_grant_n;
            dept_grant  <= dept_grant_n;
            outer_open  <= outer_open_n;
            inner_open  <= inner_open_n;
            fill        <= fill_n;
            drain       <= drain_n;
            busy        <= busy_n;
        end
    end

endmodule

// File: tb/tb_lock_scheduler.sv
// Bench for lock_scheduler: scenario table, corner-case sequences and random traffic against a phase-list model.
`timescale 1ns/1ps
module tb_lock_scheduler;

    localparam int LMAX = 7;
    localparam int GC   = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       arr_i, dept_i, hold_i;
    logic       arr_grant, dept_grant, outer_open, inner_open, fill, drain, busy;
    logic [2:0] water_level;

    int checks = 0;
    int errors = 0;

    lock_scheduler #(.LEVEL_MAX(LMAX), .GATE_CYCLES(GC)) dut (
        .clk        (clk),
        .reset      (reset),
        .arr_req    (arr_i),
        .dept_req   (dept_i),
`ifdef LOCK_HOLD_EN
        .hold       (hold_i),
`endif
        .arr_grant  (arr_grant),
        .dept_grant (dept_grant),
        .outer_open (outer_open),
        .inner_open (inner_open),
        .fill       (fill),
        .drain      (drain),
        .water_level(water_level),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Reference model: a passage is a list of (activity, duration) phases
    typedef enum int {P_NONE, P_FILL, P_DRAIN, P_OUTER, P_INNER} phase_e;
    phase_e ph_q[$];
    int     len_q[$];
    phase_e cur;
    int     rem;
    int     m_level;
    bit     m_ap, m_dp, m_ag, m_dg;

    function automatic void m_reset();
        ph_q.delete();
        len_q.delete();
        cur = P_NONE; rem = 0; m_level = 0;
        m_ap = 0; m_dp = 0; m_ag = 0; m_dg = 0;
    endfunction

    function automatic void m_next_phase();
        if (ph_q.size() > 0) begin
            cur = ph_q.pop_front();
            rem = len_q.pop_front();
        end else begin
            cur = P_NONE;
            rem = 0;
        end
    endfunction

    function automatic void m_start(input bit dept);
        int entry = dept ? LMAX : 0;
        if (m_level != entry) begin
            ph_q.push_back(m_level < entry ? P_FILL : P_DRAIN);
            len_q.push_back(m_level < entry ? entry - m_level : m_level - entry);
        end
        ph_q.push_back(dept ? P_INNER : P_OUTER); len_q.push_back(GC);
        ph_q.push_back(dept ? P_DRAIN : P_FILL);  len_q.push_back(LMAX);
        ph_q.push_back(dept ? P_OUTER : P_INNER); len_q.push_back(GC);
        m_next_phase();
    endfunction

    function automatic void m_step(input bit a, input bit d, input bit h);
        bit was_idle = (cur == P_NONE);
        bit ea, ed, take_d;
        if (cur == P_FILL && m_level < LMAX) m_level++;
        if (cur == P_DRAIN && m_level > 0) m_level--;
        m_ag = 0;
        m_dg = 0;
        if (!was_idle) begin
            m_ap |= a;
            m_dp |= d;
            if (!((cur == P_OUTER || cur == P_INNER) && h)) rem--;
            if (rem == 0) m_next_phase();
        end else begin
            ea = a | m_ap;
            ed = d | m_dp;
            if (ea | ed) begin
                take_d = ed && (!ea || m_level == LMAX);
                if (take_d) begin m_dg = 1; m_dp = 0; end
                else        begin m_ag = 1; m_ap = 0; end
                m_start(take_d);
            end
        end
    endfunction

    function automatic logic [9:0] dut_vec();
        return {arr_grant, dept_grant, outer_open, inner_open, fill, drain, busy, water_level};
    endfunction

    function automatic logic [9:0] model_vec();
        return {m_ag, m_dg, cur == P_OUTER, cur == P_INNER, cur == P_FILL,
                cur == P_DRAIN, cur != P_NONE, 3'(m_level)};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: actual %0h required %0h", name, $time, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        m_step(arr_i, dept_i, hold_i);
        #1;
        check("cycle", 32'(dut_vec()), 32'(model_vec()));
        check("invariant", 32'({fill & drain, outer_open & inner_open,
                                (outer_open | inner_open) & (fill | drain)}), 32'(0));
    endtask

    task automatic wait_idle(input int limit);
        int n = 0;
        while (busy && n < limit) begin
            tick();
            n++;
        end
        check("idle_reached", 32'(busy), 32'(0));
    endtask

    typedef struct {
        bit arr;
        bit dept;
        int start_level;
        int exp_busy;
        int exp_fill;
        int exp_drain;
        int exp_outer;
        int exp_inner;
        int exp_end_level;
    } vec_t;

    vec_t vecs[6];
    int   nb, nf, nd, no, ni, ng_a, ng_d;

    initial begin
        vecs[0] = '{1, 0, 0, 15, 7, 0, 4, 4, 7};
        vecs[1] = '{0, 1, 7, 15, 0, 7, 4, 4, 0};
        vecs[2] = '{0, 1, 0, 22, 7, 7, 4, 4, 0};
        vecs[3] = '{1, 0, 0, 15, 7, 0, 4, 4, 7};
        vecs[4] = '{1, 0, 7, 22, 7, 7, 4, 4, 7};
        vecs[5] = '{0, 1, 7, 15, 0, 7, 4, 4, 0};

        reset = 1'b1; arr_i = 1'b0; dept_i = 1'b0; hold_i = 1'b0;
        m_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", 32'(dut_vec()), 32'(0));
        reset = 1'b0;

        // Single-passage scenarios: count how long each output is active
        foreach (vecs[i]) begin
            check("start_level", 32'(water_level), 32'(vecs[i].start_level));
            arr_i = vecs[i].arr; dept_i = vecs[i].dept;
            tick();
            arr_i = 1'b0; dept_i = 1'b0;
            check("grant", 32'({arr_grant, dept_grant}), 32'({vecs[i].arr, vecs[i].dept}));
            nb = 0; nf = 0; nd = 0; no = 0; ni = 0;
            for (int c = 0; c < 100; c++) begin
                if (!busy) break;
                nb++;
                nf += int'(fill); nd += int'(drain);
                no += int'(outer_open); ni += int'(inner_open);
                tick();
            end
            check("busy_len",  32'(nb), 32'(vecs[i].exp_busy));
            check("fill_len",  32'(nf), 32'(vecs[i].exp_fill));
            check("drain_len", 32'(nd), 32'(vecs[i].exp_drain));
            check("outer_len", 32'(no), 32'(vecs[i].exp_outer));
            check("inner_len", 32'(ni), 32'(vecs[i].exp_inner));
            check("end_level", 32'(water_level), 32'(vecs[i].exp_end_level));
        end

        // Both requests at level 0: arrival first, then departure without PREP
        arr_i = 1'b1; dept_i = 1'b1;
        tick();
        arr_i = 1'b0;
        check("both_first", 32'({arr_grant, dept_grant}), 32'(2'b10));
        tick();
        dept_i = 1'b0;
        wait_idle(40);
        check("both_mid_level", 32'(water_level), 32'(7));
        tick();
        check("both_second", 32'({dept_grant, inner_open, fill, drain}), 32'(4'b1100));
        wait_idle(40);
        check("both_end_level", 32'(water_level), 32'(0));

        // Three arrival pulses during a passage collapse into one extra passage
        ng_a = 0; ng_d = 0;
        for (int c = 0; c < 80; c++) begin
            arr_i = (c == 0 || c == 3 || c == 6 || c == 10);
            tick();
            ng_a += int'(arr_grant);
            ng_d += int'(dept_grant);
        end
        arr_i = 1'b0;
        check("pulse_arr_grants", 32'(ng_a), 32'(2));
        check("pulse_dept_grants", 32'(ng_d), 32'(0));
        check("pulse_end", 32'({busy, water_level}), 32'({1'b0, 3'd7}));

        // Asynchronous reset mid-LEVEL discards the pending departure
        dept_i = 1'b1; tick(); dept_i = 1'b0;
        tick();
        dept_i = 1'b1; tick(); dept_i = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (drain && water_level == 3'd3) break;
            tick();
        end
        check("pre_reset", 32'({drain, water_level}), 32'({1'b1, 3'd3}));
        #1 reset = 1'b1;
        #1;
        check("async_reset", 32'(dut_vec()), 32'(0));
        m_reset();
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b0;
        nb = 0;
        for (int c = 0; c < 30; c++) begin
            tick();
            nb += int'(busy | arr_grant | dept_grant);
        end
        check("no_resume", 32'(nb), 32'(0));

`ifdef LOCK_HOLD_EN
        // Five held cycles stretch the outer-gate window from 4 to 9 cycles
        arr_i = 1'b1; tick(); arr_i = 1'b0;
        no = int'(outer_open);
        tick();
        no += int'(outer_open);
        hold_i = 1'b1;
        repeat (5) begin
            tick();
            no += int'(outer_open);
        end
        hold_i = 1'b0;
        for (int c = 0; c < 50; c++) begin
            tick();
            if (!outer_open) break;
            no++;
        end
        check("hold_outer_len", 32'(no), 32'(9));
        check("hold_then_fill", 32'(fill), 32'(1));
        wait_idle(40);
        check("hold_end_level", 32'(water_level), 32'(7));
`endif

        // Random traffic against the model
        for (int c = 0; c < 4000; c++) begin
            arr_i  = ($urandom_range(0, 11) == 0);
            dept_i = ($urandom_range(0, 11) == 0);
`ifdef LOCK_HOLD_EN
            hold_i = ($urandom_range(0, 3) == 0);
`endif
            tick();
        end
        arr_i = 1'b0; dept_i = 1'b0; hold_i = 1'b0;
        wait_idle(200);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
